cos_arbiter: RTL and testbench
==============================

# cos_arbiter

Round-robin arbiter and sequencer that shares one `taylor_horner_rtl` cosine core among `N_REQ` requesters. It accepts angle requests, drives the core's start/angle inputs and waits for its ready. It then captures the result and returns it to the originating requester as a one-cycle response pulse. Sits between the angle-producing clients and the single Horner-scheme core, which it instantiates internally.

## Interface
- `N_REQ`, 4 — number of requesters (2..8)
- `DATA_W`, 24 — angle/cos width, fixed point with 10 fractional bits (1.0 = 1024)
- `START_CYCLES`, 3 — cycles `start` is held high per job
- `TIMEOUT_CYCLES`, 64 — watchdog limit (used only when `COS_ARB_TIMEOUT_EN` is defined)

Ports:
- `clock`  in  1  — single clock, rising edge
- `reset`  in  1  — synchronous, active-high; also drives the core's `reset`
- `req_valid`  in  N_REQ  — per-requester request
- `req_angle`  in  N_REQ*DATA_W  — packed angles, requester i at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  N_REQ  — one-hot accept; a request transfers when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  N_REQ  — one-hot, one-cycle result pulse
- `rsp_cos`  out  DATA_W  — result, valid only while any `rsp_valid` bit is high
- `rsp_err`  out  1  — timeout flag, pulses with `rsp_valid` (present only with `COS_ARB_TIMEOUT_EN`)
- `busy`  out  1  — high in every state except IDLE

## Operation
- FSM states: IDLE, START, WAIT, CAPTURE, plus ABORT when the macro is enabled.
- **IDLE:** if any `req_valid` bit is high, select index g round-robin, searching from `last_grant+1` with wrap-around.
  - `req_ready[g]` is asserted combinationally in that cycle.
  - Latch `req_angle[g]` and g, set `last_grant <= g`, go to START.
  - `req_ready` is all-zero in every other state.
- **START:** core `start=1` and `angle_in` = latched angle, for exactly `START_CYCLES` cycles, then go to WAIT.
- **WAIT:** hold `start=0` and `angle_in` stable.
- **Ready detection:** a rising edge of `ready_out` (high now, low the previous cycle) is detected in both START and WAIT.
  - On detection, go to CAPTURE, cutting START short if needed.
- **CAPTURE:** register `rsp_cos <= cos_out` and `rsp_valid <= onehot(g)`, then go to IDLE.
  - The response is therefore visible during the first IDLE cycle after CAPTURE.
- Requesters may drop `req_valid` before being granted; nothing is recorded for them. Only one job is outstanding at any time.
- `rsp_cos` holds its last value between responses. Benches check it only while `rsp_valid` is non-zero.
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_cos=0`, `rsp_err=0`, `busy=0`, state IDLE, `last_grant=N_REQ-1` (requester 0 has first priority).
- **Reset mid-job:** return to IDLE next cycle. No `rsp_valid` is issued for the aborted job; the core is reset by the same signal.

## Timing
- Accept cycle T (IDLE) → START in T+1..T+START_CYCLES → WAIT.
- With the core's `ready_out` edge at cycle R: CAPTURE at R+1, `rsp_valid` visible at R+2.
- Back-to-back: a new request can be accepted in the same cycle the previous `rsp_valid` is visible.
- Per-job overhead beyond core latency: 1 accept cycle + 1 CAPTURE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Other requesters must keep `req_valid` high.

## Configuration
- `COS_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in START/WAIT. On reaching `TIMEOUT_CYCLES` without a ready edge, go to ABORT.
  - ABORT pulses the core reset for 1 cycle, issues `rsp_valid=onehot(g)` with `rsp_err=1` and `rsp_cos=0`, then returns to IDLE.
  - Normal responses carry `rsp_err=0`.
- Undefined: no counter, no ABORT state, no `rsp_err` port; WAIT blocks indefinitely.

## Structure
- Package `cos_arb_pkg`:
  - `FXP_FRAC=10`, `FXP_ONE=1024`, `DATA_W` default
  - state enum `cos_arb_state_t`
- Sub-module `rr_picker`: combinational round-robin one-hot selector (inputs `req`, `last_grant`; outputs `grant` one-hot, `index`).
- `taylor_horner_rtl` is instantiated once inside `cos_arbiter`.

## Test plan
- Single request, requester 0, angle 512 (0.5) → one `rsp_valid[0]` pulse, `rsp_cos` within 897..900 (cos 0.5 ≈ 0.8776), `busy` low afterwards.
- Requester 2, angle 0 → `rsp_valid[2]`, `rsp_cos` = 1024 ±1; no other `rsp_valid` bits toggle.
- All four requesters assert simultaneously and hold → grants and responses in order 0,1,2,3.
  - Each `rsp_valid` is exactly 1 cycle; next grant occurs in the cycle of the previous response.
- After a grant to 1, requesters 0 and 2 pending → 2 is granted before 0.
- `reset` asserted for 1 cycle during WAIT → outputs at reset values next cycle, no response; a fresh request afterwards completes normally.
- With `COS_ARB_TIMEOUT_EN`, core `ready_out` forced low → after 64 cycles in START/WAIT, `rsp_valid[g]=1`, `rsp_err=1`, `rsp_cos=0`, state IDLE.

Source files
------------

// File: rtl/cos_arb_pkg.sv
// Shared definitions for the cosine arbiter slice: fixed-point format,
// default data width and the sequencer state encoding.
// The ABORT state exists only when COS_ARB_TIMEOUT_EN is defined.
package cos_arb_pkg;

  localparam int FXP_FRAC       = 10;
  localparam int FXP_ONE        = 1 << FXP_FRAC;
  localparam int DATA_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
`ifdef COS_ARB_TIMEOUT_EN
    , ST_ABORT
`endif
  } cos_arb_state_t;

endpackage

// File: rtl/cos_arbiter_rr_picker.sv
// Combinational round-robin selector: picks the first requester after
// last_grant (wrapping) and reports it both one-hot and as an index.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index
);

  int          cand;
  logic [IW-1:0] cidx;

  // Scan farthest-to-nearest so the closest requester after last_grant wins.
  always_comb begin
    grant = '0;
    index = '0;
    cand  = 0;
    cidx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = int'(last_grant) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = IW'(cand);
      if (req[cidx]) begin
        grant       = '0;
        grant[cidx] = 1'b1;
        index       = cidx;
      end
    end
  end

endmodule

// File: rtl/taylor_horner_rtl.sv
// Multi-cycle cosine core: cos(x) = 1 - x^2/2 + x^4/24 - x^6/720 + x^8/40320
// evaluated in Horner form over x^2 with a Q20 internal accumulator.
// Angle and result are Q10; accurate for angles within roughly +/-pi.
// ready_out rises when a result is available and drops when a new job starts.
module taylor_horner_rtl
  import cos_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] angle_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] cos_out
);

  localparam int AF = 2 * FXP_FRAC;
  localparam logic signed [63:0] C0 = 64'(FXP_ONE) <<< FXP_FRAC;
  localparam logic signed [63:0] C1 = -(C0 >>> 1);
  localparam logic signed [63:0] C2 = 64'sd43691;   // 1/24 in Q20
  localparam logic signed [63:0] C3 = -64'sd1456;   // -1/720 in Q20
  localparam logic signed [63:0] C4 = 64'sd26;      // 1/40320 in Q20

  logic               running_reg;
  logic [2:0]         step_reg;
  logic signed [63:0] x_reg, x2_reg, acc_reg;
  logic signed [63:0] coef, acc_next, acc_round;

  // Coefficient for the current Horner step (step 1 -> C3 ... step 4 -> C0).
  always_comb begin
    coef = C0;
    unique case (step_reg)
      3'd1:    coef = C3;
      3'd2:    coef = C2;
      3'd3:    coef = C1;
      default: coef = C0;
    endcase
  end

  assign acc_next  = coef + ((acc_reg * x2_reg) >>> AF);
  assign acc_round = acc_next + (64'sd1 <<< (FXP_FRAC - 1));

  // Step 0 squares the angle, steps 1..4 fold one coefficient each.
  always_ff @(posedge clock) begin
    if (reset) begin
      running_reg <= 1'b0;
      ready_out   <= 1'b0;
      cos_out     <= '0;
      step_reg    <= '0;
      x_reg       <= '0;
      x2_reg      <= '0;
      acc_reg     <= '0;
    end else if (!running_reg) begin
      if (start) begin
        running_reg <= 1'b1;
        ready_out   <= 1'b0;
        step_reg    <= '0;
        x_reg       <= 64'($signed(angle_in)) <<< FXP_FRAC;
      end
    end else begin
      step_reg <= step_reg + 3'd1;
      if (step_reg == 3'd0) begin
        x2_reg  <= (x_reg * x_reg) >>> AF;
        acc_reg <= C4;
      end else begin
        acc_reg <= acc_next;
      end
      if (step_reg == 3'd4) begin
        running_reg <= 1'b0;
        ready_out   <= 1'b1;
        cos_out     <= DATA_W'(acc_round >>> FXP_FRAC);
      end
    end
  end

endmodule

// File: rtl/cos_arbiter.sv
// Round-robin arbiter/sequencer sharing one taylor_horner_rtl core among
// N_REQ requesters. One job outstanding at a time; the result returns to the
// granted requester as a one-cycle rsp_valid pulse.
// Optional watchdog with ABORT state and rsp_err port: COS_ARB_TIMEOUT_EN.
module cos_arbiter
  import cos_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int START_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_angle,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_cos,
`ifdef COS_ARB_TIMEOUT_EN
  output logic                    rsp_err,
`endif
  output logic                    busy
);

  localparam int IW      = $clog2(N_REQ);
  // One counter times both the start pulse and the watchdog.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > START_CYCLES) ? TIMEOUT_CYCLES : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  cos_arb_state_t    state_reg, state_next;
  logic [IW-1:0]     last_grant_reg, gidx_reg, pick_index;
  logic [N_REQ-1:0]  pick_grant;
  logic [DATA_W-1:0] angle_reg;
  logic [DATA_W-1:0] angle_arr [N_REQ];
  logic [CNT_W-1:0]  cyc_reg;
  logic              ready_prev_reg, ready_edge, start_done;
  logic              core_start, core_reset, core_ready;
  logic [DATA_W-1:0] core_cos;

  // Unpack the flat angle bus into one entry per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_angle
    assign angle_arr[gi] = req_angle[gi*DATA_W +: DATA_W];
  end

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (pick_grant),
    .index      (pick_index)
  );

  taylor_horner_rtl #(.DATA_W(DATA_W)) u_core (
    .clock     (clock),
    .reset     (core_reset),
    .start     (core_start),
    .angle_in  (angle_reg),
    .ready_out (core_ready),
    .cos_out   (core_cos)
  );

  assign ready_edge = core_ready & ~ready_prev_reg;
  assign start_done = (cyc_reg == CNT_W'(START_CYCLES - 1));
`ifdef COS_ARB_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = (cyc_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a ready edge always takes priority so START can be cut short.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (|req_valid) state_next = ST_START;
      ST_START: begin
        if (ready_edge)       state_next = ST_CAPTURE;
`ifdef COS_ARB_TIMEOUT_EN
        else if (timeout_hit) state_next = ST_ABORT;
`endif
        else if (start_done)  state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (ready_edge)       state_next = ST_CAPTURE;
`ifdef COS_ARB_TIMEOUT_EN
        else if (timeout_hit) state_next = ST_ABORT;
`endif
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: accept strobe, busy, core control.
  always_comb begin
    req_ready  = (state_reg == ST_IDLE) ? pick_grant : '0;
    busy       = (state_reg != ST_IDLE);
    core_start = (state_reg == ST_START);
`ifdef COS_ARB_TIMEOUT_EN
    core_reset = reset | (state_reg == ST_ABORT);
`else
    core_reset = reset;
`endif
  end

  // Job datapath: latch the grant, time the start pulse, register the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= IW'(N_REQ - 1);
      gidx_reg       <= '0;
      angle_reg      <= '0;
      cyc_reg        <= '0;
      ready_prev_reg <= 1'b0;
      rsp_valid      <= '0;
      rsp_cos        <= '0;
`ifdef COS_ARB_TIMEOUT_EN
      rsp_err        <= 1'b0;
`endif
    end else begin
      ready_prev_reg <= core_ready;
      rsp_valid      <= '0;
`ifdef COS_ARB_TIMEOUT_EN
      rsp_err        <= 1'b0;
`endif
      unique case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            angle_reg      <= angle_arr[pick_index];
            gidx_reg       <= pick_index;
            last_grant_reg <= pick_index;
            cyc_reg        <= '0;
          end
        end
        ST_START:   cyc_reg <= cyc_reg + CNT_W'(1);
`ifdef COS_ARB_TIMEOUT_EN
        ST_WAIT:    cyc_reg <= cyc_reg + CNT_W'(1);
        ST_ABORT: begin
          rsp_valid <= N_REQ'(1) << gidx_reg;
          rsp_cos   <= '0;
          rsp_err   <= 1'b1;
        end
`endif
        ST_CAPTURE: begin
          rsp_valid <= N_REQ'(1) << gidx_reg;
          rsp_cos   <= core_cos;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cos_arbiter.sv
// Directed bench for cos_arbiter with an expected-grant / expected-response
// scoreboard. Build with COS_ARB_TIMEOUT_EN to include the watchdog step.
module tb_cos_arbiter;

  localparam int N_REQ          = 4;
  localparam int DATA_W         = 24;
  localparam int START_CYCLES   = 3;
  localparam int TIMEOUT_CYCLES = 64;

  typedef struct {
    int idx;
    int cos;
    int tol;
    bit err;
  } exp_t;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_angle;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_cos;
  logic                    busy;
`ifdef COS_ARB_TIMEOUT_EN
  logic                    rsp_err;
`endif

  int               n_vec = 0;
  int               n_miss = 0;
  int               grant_q[$];
  exp_t             rsp_q[$];
  logic [N_REQ-1:0] drop_mask = '0;
  logic [N_REQ-1:0] prev_rsp = '0;
  int               start_seen = 0;
  int               last_cos = 0;
  bit               expect_b2b = 0;

  cos_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W),
    .START_CYCLES(START_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_cos   (rsp_cos),
`ifdef COS_ARB_TIMEOUT_EN
    .rsp_err   (rsp_err),
`endif
    .busy      (busy)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N_REQ-1:0] onehot(input int i);
    return N_REQ'(1) << i;
  endfunction

  function automatic int exp_cos(input int a);
    real r;
    r = $cos(real'(a) / 1024.0) * 1024.0;
    return int'(r);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    logic ok;
    ok = (obs >= lo) && (obs <= hi);
    n_vec++;
    assert (ok === 1'b1) else begin
      n_miss++;
      $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic set_req(input int i, input int angle);
    req_angle[i*DATA_W +: DATA_W] = DATA_W'(angle);
    req_valid[i] = 1'b1;
  endtask

  task automatic push_job(input int i, input int angle, input int tol);
    grant_q.push_back(i);
    rsp_q.push_back('{i, exp_cos(angle), tol, 1'b0});
  endtask

  // One clock: sample at negedge, score grants/responses, drop granted requests after the edge.
  task automatic cycle();
    logic [N_REQ-1:0] hs;
    int   pend;
    int   g;
    exp_t e;
    @(negedge clock);
    hs   = req_ready & req_valid;
    pend = grant_q.size();
    if (hs != '0) begin
      if (grant_q.size() == 0) chk("unexpected_grant", 64'(hs), 64'(0));
      else begin
        g = grant_q.pop_front();
        chk("grant_order", 64'(hs), 64'(onehot(g)));
      end
      drop_mask = drop_mask | hs;
    end
    if (dut.core_start === 1'b1) start_seen++;
    if (rsp_valid != '0) begin
      if (expect_b2b && pend > 0) chk("b2b_grant", 64'(hs != '0), 64'(1));
      if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
      else begin
        e = rsp_q.pop_front();
        last_cos = int'($signed(rsp_cos));
        chk("rsp_onehot", 64'(rsp_valid), 64'(onehot(e.idx)));
        chk_range("rsp_cos", last_cos, e.cos - e.tol, e.cos + e.tol);
`ifdef COS_ARB_TIMEOUT_EN
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
`endif
        chk("start_len", 64'(start_seen), 64'(START_CYCLES));
        start_seen = 0;
      end
    end
    if (prev_rsp != '0) chk("rsp_pulse_width", 64'(rsp_valid), 64'(0));
    prev_rsp = rsp_valid;
    @(posedge clock);
    #1;
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
  endtask

  task automatic run_until_quiet(input int limit);
    int n;
    bit quiet;
    n = 0;
    quiet = 0;
    while (!quiet && n < limit) begin
      cycle();
      n++;
      quiet = (grant_q.size() == 0) && (rsp_q.size() == 0) && (busy === 1'b0);
    end
    chk("quiet_within_budget", 64'(quiet), 64'(1));
  endtask

  task automatic wait_granted(input int limit);
    int n;
    n = 0;
    while (grant_q.size() != 0 && n < limit) begin
      cycle();
      n++;
    end
    chk("grant_within_budget", 64'(grant_q.size()), 64'(0));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_angle = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_cos",   64'(rsp_cos),   64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
`ifdef COS_ARB_TIMEOUT_EN
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
`endif
    @(posedge clock);
    #1;

    // Requester 0, angle 0.5.
    set_req(0, 512);
    push_job(0, 512, 1);
    run_until_quiet(100);
    chk_range("cos_half", last_cos, 897, 900);
    chk("busy_after_job", 64'(busy), 64'(0));
    chk("rsp_cleared", 64'(rsp_valid), 64'(0));

    // Requester 2, angle 0.
    set_req(2, 0);
    push_job(2, 0, 1);
    run_until_quiet(100);

    // Reset during WAIT aborts the job silently.
    set_req(1, 256);
    grant_q.push_back(1);
    wait_granted(20);
    repeat (3) cycle();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy",      64'(busy),      64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_rsp_cos",   64'(rsp_cos),   64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clock);
    #1;
    prev_rsp   = '0;
    start_seen = 0;
    repeat (20) cycle();
    set_req(3, 800);
    push_job(3, 800, 2);
    run_until_quiet(100);

    // All four simultaneously; last grant was 3, so order is 0,1,2,3.
    set_req(0, 100);
    set_req(1, 300);
    set_req(2, 700);
    set_req(3, 1200);
    for (int i = 0; i < 4; i++) begin
      push_job(i, (i == 0) ? 100 : (i == 1) ? 300 : (i == 2) ? 700 : 1200, 2);
    end
    expect_b2b = 1;
    run_until_quiet(400);
    expect_b2b = 0;

    // After a grant to 1, pending 0 and 2 resolve as 2 then 0.
    set_req(1, 400);
    push_job(1, 400, 2);
    wait_granted(20);
    set_req(0, 150);
    set_req(2, 900);
    push_job(2, 900, 2);
    push_job(0, 150, 2);
    run_until_quiet(300);

`ifdef COS_ARB_TIMEOUT_EN
    // Core never signals ready: watchdog response with error flag.
    force dut.u_core.ready_out = 1'b0;
    set_req(0, 10);
    grant_q.push_back(0);
    rsp_q.push_back('{0, 0, 0, 1'b1});
    run_until_quiet(200);
    release dut.u_core.ready_out;
    chk("abort_idle", 64'(busy), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
